// File: rtl/record_mode_pkg.sv
// -----------------------------------------------------------------------------
// record_mode_pkg
//   Definitions shared by the record and playback paths.
//   - NOTE_W / SHIFT_W / WORD_W : storage word geometry
//   - COUNT_W                   : width of the per-take word counter
//   - rec_state_t               : record controller states
//   - pack_word()               : builds the storage word {notes[9:2], shift[1:0]}
// -----------------------------------------------------------------------------
package record_mode_pkg;

    localparam int NOTE_W  = 8;
    localparam int SHIFT_W = 2;
    localparam int WORD_W  = NOTE_W + SHIFT_W;
    localparam int COUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RECORD = 2'd2,
        DRAIN  = 2'd3
    } rec_state_t;

    // Notes occupy the upper bits and the octave shift the lower bits; the
    // playback path unpacks with exactly this layout.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [NOTE_W-1:0]  notes,
        input logic [SHIFT_W-1:0] shift
    );
        return {notes, shift};
    endfunction

endpackage

// File: rtl/record_mode_sample_tick.sv
// -----------------------------------------------------------------------------
// sample_tick
//   Free-running divider that produces a one-cycle tick every TICK_DIV enabled
//   cycles. The counter runs 0..TICK_DIV-1 and the tick coincides with the
//   wrap back to 0.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     enable     : counter advances only while high
//     clear      : synchronous reset of the counter to 0 (wins over enable)
//     tick       : high for the cycle in which the counter wraps
// -----------------------------------------------------------------------------
module sample_tick #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tick = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/record_mode.sv
// -----------------------------------------------------------------------------
// record_mode
//   Samples the live keyboard at SAMPLE_HZ, packs each sample into a storage
//   word {notes, shift} and hands it to song storage over a valid/ready port.
//   Leading silence after arming is skipped; the first non-silent sample starts
//   the take and re-phases the sample divider.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     rec_start   : pulse, arms recording (ignored outside IDLE)
//     rec_stop    : pulse, ends the take (ARMED -> IDLE, RECORD -> DRAIN)
//     notes       : live key levels, 1 = pressed
//     shift       : live octave shift
//     input_ready : storage accepts the presented word this cycle
//     write_en    : data_in holds a valid word
//     data_in     : packed word to storage
//     recording   : take in progress (ARMED, RECORD, DRAIN)
//     word_count  : words accepted in the current take, saturates at MAX_WORDS
//     overrun     : sticky, a sample was dropped while a word was pending
// -----------------------------------------------------------------------------
module record_mode
    import record_mode_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int SAMPLE_HZ = 8,
    parameter int MAX_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rec_start,
    input  logic               rec_stop,
    input  logic [NOTE_W-1:0]  notes,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               input_ready,
    output logic               write_en,
    output logic [WORD_W-1:0]  data_in,
    output logic               recording,
    output logic [COUNT_W-1:0] word_count,
    output logic               overrun
);

    localparam int                 TICK_DIV = CLK_FREQ / SAMPLE_HZ;
    localparam logic [COUNT_W-1:0] MAX_CNT  = COUNT_W'(MAX_WORDS);

    if (MAX_WORDS < 1 || MAX_WORDS > 65535 || TICK_DIV < 1) begin : g_bad_params
        $error("record_mode: need 1 <= MAX_WORDS <= 65535 and CLK_FREQ >= SAMPLE_HZ");
    end

    rec_state_t state, state_nxt;

    logic tick;
    logic tick_en;
    logic tick_clr;
    logic capture;
    logic set_overrun;
    logic room;
    logic transfer;
    logic full_hit;

    // Handshake qualifiers. A full take accepts nothing more, which is what
    // keeps word_count from ever passing MAX_WORDS.
    assign room     = (word_count < MAX_CNT);
    assign transfer = write_en && input_ready && room;
    assign full_hit = transfer && (word_count == MAX_CNT - COUNT_W'(1));

    sample_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_sample_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (tick_en),
        .clear  (tick_clr),
        .tick   (tick)
    );

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves the
        // signal unassigned, which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rec_start) state_nxt = ARMED;
            end
            ARMED: begin
                if (rec_stop)            state_nxt = IDLE;
                else if (notes != '0)    state_nxt = RECORD;
            end
            RECORD: begin
                // Filling storage and a stop request both end in DRAIN; the
                // limit is what suppresses any further capture.
                if (full_hit || rec_stop) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!write_en || transfer) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------ output/control
    always_comb begin
        tick_en     = 1'b0;
        tick_clr    = 1'b0;
        capture     = 1'b0;
        set_overrun = 1'b0;
        recording   = (state != IDLE);
        case (state)
            ARMED: begin
                // First sound starts the take and aligns the divider phase to it.
                if (!rec_stop && notes != '0) begin
                    capture  = 1'b1;
                    tick_clr = 1'b1;
                end
            end
            RECORD: begin
                tick_en = 1'b1;
                // A tick may capture only if the output slot is free by the edge:
                // either nothing is pending or the pending word leaves now.
                if (tick && !rec_stop && !full_hit && (!write_en || transfer))
                    capture = 1'b1;
                if (tick && write_en && !transfer)
                    set_overrun = 1'b1;
            end
            default: ;
        endcase
    end

    // ----------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en   <= 1'b0;
            data_in    <= '0;
            word_count <= '0;
            overrun    <= 1'b0;
        end else begin
            // data_in changes only on capture, so it is stable until accepted.
            if (capture) begin
                write_en <= 1'b1;
                data_in  <= pack_word(notes, shift);
            end else if (transfer) begin
                write_en <= 1'b0;
            end

            if (state == IDLE && rec_start) begin
                word_count <= '0;
                overrun    <= 1'b0;
            end else begin
                if (transfer)    word_count <= word_count + COUNT_W'(1);
                if (set_overrun) overrun    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_record_mode.sv
// -----------------------------------------------------------------------------
// tb_record_mode
//   Directed bench for record_mode with TICK_DIV = 10 and MAX_WORDS = 4.
//   Inputs change 1 ns after a rising edge; outputs are checked at that point,
//   i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_record_mode;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rec_start;
    logic       rec_stop;
    logic [7:0] notes;
    logic [1:0] shift;
    logic       input_ready;
    logic       write_en;
    logic [9:0] data_in;
    logic       recording;
    logic [15:0] word_count;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    record_mode #(
        .CLK_FREQ  (100),
        .SAMPLE_HZ (10),
        .MAX_WORDS (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rec_start   (rec_start),
        .rec_stop    (rec_stop),
        .notes       (notes),
        .shift       (shift),
        .input_ready (input_ready),
        .write_en    (write_en),
        .data_in     (data_in),
        .recording   (recording),
        .word_count  (word_count),
        .overrun     (overrun)
    );

    typedef struct {
        logic        start;
        logic        stop;
        logic [7:0]  notes;
        logic [1:0]  shift;
        logic        ready;
        int          cycles;
        logic        we;
        logic [9:0]  data;
        logic        rec;
        logic [15:0] cnt;
        logic        ovr;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic s, input logic p, input logic [7:0] n,
                                input logic [1:0] sh, input logic r, input int cyc,
                                input logic we, input logic [9:0] d, input logic rec,
                                input logic [15:0] c, input logic ov);
        vec_t v;
        v.start = s;  v.stop = p;  v.notes = n;  v.shift = sh;  v.ready = r;
        v.cycles = cyc;
        v.we = we;  v.data = d;  v.rec = rec;  v.cnt = c;  v.ovr = ov;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic we, input logic [9:0] d,
                            input logic rec, input logic [15:0] c, input logic ov);
        check({tag, ".write_en"},   32'(write_en),   32'(we));
        check({tag, ".data_in"},    32'(data_in),    32'(d));
        check({tag, ".recording"},  32'(recording),  32'(rec));
        check({tag, ".word_count"}, 32'(word_count), 32'(c));
        check({tag, ".overrun"},    32'(overrun),    32'(ov));
    endtask

    task automatic drive(input logic s, input logic p, input logic [7:0] n,
                         input logic [1:0] sh, input logic r);
        rec_start   = s;
        rec_stop    = p;
        notes       = n;
        shift       = sh;
        input_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hard stop in case something above ever blocks.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 8'h00, 2'b00, 0);
        #22;
        chk_outs("reset", 0, 10'h000, 0, 0, 0);
        rst_n = 1'b1;

        // Arm, skip silence, then four words 10 cycles apart until full.
        vecs[0]  = mk(1, 0, 8'h00, 2'b00, 0,  1, 0, 10'h000, 1, 0, 0);
        vecs[1]  = mk(0, 0, 8'h00, 2'b00, 0, 30, 0, 10'h000, 1, 0, 0);
        vecs[2]  = mk(0, 0, 8'h01, 2'b10, 1,  1, 1, 10'h006, 1, 0, 0);
        vecs[3]  = mk(0, 0, 8'h02, 2'b00, 1,  1, 0, 10'h006, 1, 1, 0);
        vecs[4]  = mk(0, 0, 8'h02, 2'b00, 1,  8, 0, 10'h006, 1, 1, 0);
        vecs[5]  = mk(0, 0, 8'h02, 2'b00, 1,  1, 1, 10'h008, 1, 1, 0);
        vecs[6]  = mk(0, 0, 8'h03, 2'b01, 1,  1, 0, 10'h008, 1, 2, 0);
        vecs[7]  = mk(0, 0, 8'h03, 2'b01, 1,  8, 0, 10'h008, 1, 2, 0);
        vecs[8]  = mk(0, 0, 8'h03, 2'b01, 1,  1, 1, 10'h00D, 1, 2, 0);
        vecs[9]  = mk(0, 0, 8'h04, 2'b11, 1,  1, 0, 10'h00D, 1, 3, 0);
        vecs[10] = mk(0, 0, 8'h04, 2'b11, 1,  8, 0, 10'h00D, 1, 3, 0);
        vecs[11] = mk(0, 0, 8'h04, 2'b11, 1,  1, 1, 10'h013, 1, 3, 0);
        vecs[12] = mk(0, 0, 8'h05, 2'b00, 1,  1, 0, 10'h013, 1, 4, 0);
        vecs[13] = mk(0, 0, 8'h05, 2'b00, 1,  1, 0, 10'h013, 0, 4, 0);
        vecs[14] = mk(0, 0, 8'h05, 2'b00, 1, 12, 0, 10'h013, 0, 4, 0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].notes, vecs[i].shift, vecs[i].ready);
            for (int c = 0; c < vecs[i].cycles; c++) begin
                step();
                chk_outs($sformatf("vec%0d.c%0d", i, c), vecs[i].we, vecs[i].data,
                         vecs[i].rec, vecs[i].cnt, vecs[i].ovr);
            end
        end

        // Backpressure across a tick: word held, overrun set, one transfer,
        // then a stop coinciding with the next tick drops that sample.
        drive(1, 0, 8'h00, 2'b00, 0); step();
        chk_outs("ovr.arm", 0, 10'h013, 1, 0, 0);
        drive(0, 0, 8'h01, 2'b00, 0); step();
        chk_outs("ovr.e0", 1, 10'h004, 1, 0, 0);
        drive(0, 0, 8'h80, 2'b00, 0);
        for (int i = 0; i < 15; i++) begin
            step();
            chk_outs($sformatf("ovr.hold%0d", i), 1, 10'h004, 1, 0, (i >= 9));
        end
        drive(0, 0, 8'h80, 2'b00, 1); step();
        chk_outs("ovr.release", 0, 10'h004, 1, 1, 1);
        drive(0, 0, 8'h80, 2'b00, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_outs($sformatf("ovr.after%0d", i), 0, 10'h004, 1, 1, 1);
        end
        drive(0, 1, 8'h80, 2'b00, 0); step();
        chk_outs("ovr.stop_tick", 0, 10'h004, 1, 1, 1);
        drive(0, 0, 8'h80, 2'b00, 0); step();
        chk_outs("ovr.idle", 0, 10'h004, 0, 1, 1);

        // Tick and transfer together (no gap, no overrun), then stop with a
        // pending word: it drains once storage is ready.
        drive(1, 0, 8'h00, 2'b00, 0); step();
        chk_outs("drn.arm", 0, 10'h004, 1, 0, 0);
        drive(0, 0, 8'h01, 2'b11, 0); step();
        chk_outs("drn.e0", 1, 10'h007, 1, 0, 0);
        drive(0, 0, 8'h20, 2'b00, 0);
        for (int i = 0; i < 9; i++) begin
            step();
            chk_outs($sformatf("drn.hold%0d", i), 1, 10'h007, 1, 0, 0);
        end
        drive(0, 0, 8'h20, 2'b00, 1); step();
        chk_outs("drn.tick_xfer", 1, 10'h080, 1, 1, 0);
        drive(0, 1, 8'h20, 2'b00, 0); step();
        chk_outs("drn.stop", 1, 10'h080, 1, 1, 0);
        drive(0, 0, 8'h20, 2'b00, 0); step();
        chk_outs("drn.wait", 1, 10'h080, 1, 1, 0);
        drive(0, 0, 8'h20, 2'b00, 1); step();
        chk_outs("drn.xfer", 0, 10'h080, 0, 2, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk_outs($sformatf("drn.quiet%0d", i), 0, 10'h080, 0, 2, 0);
        end

        // Asynchronous reset in the middle of a take with a word pending.
        drive(1, 0, 8'h00, 2'b00, 0); step();
        chk_outs("rst.arm", 0, 10'h080, 1, 0, 0);
        drive(0, 0, 8'h05, 2'b00, 1); step();
        chk_outs("rst.e0", 1, 10'h014, 1, 0, 0);
        step();
        chk_outs("rst.e1", 0, 10'h014, 1, 1, 0);
        drive(0, 0, 8'h05, 2'b00, 0);
        for (int i = 0; i < 19; i++) step();
        chk_outs("rst.pending", 1, 10'h014, 1, 1, 1);
        #2 rst_n = 1'b0;
        #1 chk_outs("rst.async", 0, 10'h000, 0, 0, 0);
        #2 rst_n = 1'b1;
        step();
        chk_outs("rst.idle", 0, 10'h000, 0, 0, 0);

        // Re-arm after reset, then stop while still armed.
        drive(1, 0, 8'h00, 2'b00, 0); step();
        chk_outs("arm.rearm", 0, 10'h000, 1, 0, 0);
        drive(0, 0, 8'h00, 2'b00, 0); step();
        chk_outs("arm.wait", 0, 10'h000, 1, 0, 0);
        drive(0, 1, 8'h00, 2'b00, 0); step();
        chk_outs("arm.stop", 0, 10'h000, 0, 0, 0);
        drive(0, 0, 8'h00, 2'b00, 0); step();
        chk_outs("arm.idle", 0, 10'h000, 0, 0, 0);

        // rec_start during RECORD must not disturb the count or tick phase.
        drive(1, 0, 8'h00, 2'b00, 1); step();
        chk_outs("ign.arm", 0, 10'h000, 1, 0, 0);
        drive(0, 0, 8'h09, 2'b00, 1); step();
        chk_outs("ign.e0", 1, 10'h024, 1, 0, 0);
        step();
        chk_outs("ign.e1", 0, 10'h024, 1, 1, 0);
        drive(1, 0, 8'h09, 2'b00, 1); step();
        chk_outs("ign.start", 0, 10'h024, 1, 1, 0);
        drive(0, 0, 8'h09, 2'b00, 1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk_outs($sformatf("ign.gap%0d", i), 0, 10'h024, 1, 1, 0);
        end
        step();
        chk_outs("ign.e10", 1, 10'h024, 1, 1, 0);
        drive(0, 1, 8'h09, 2'b00, 1); step();
        chk_outs("ign.stop_xfer", 0, 10'h024, 1, 2, 0);
        drive(0, 0, 8'h09, 2'b00, 1); step();
        chk_outs("ign.idle", 0, 10'h024, 0, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
